rob_commit_ctrl: RTL and testbench
==================================

Name: rob_commit_ctrl

Overview:
In-order commit controller (reorder buffer) for the Tomasulo core; it sequences every write into the architectural register file.
- Allocates tags to decoded instructions.
- Records completions broadcast on the CDB.
- Retires entries oldest-first, driving the regfile ROB_* write port one entry per cycle.
- Raises the pipeline-wide clear on a mispredicted branch at commit.
- Provides combinational operand lookup by tag for dispatch.

Parameters:
DEPTH, 16, number of ROB entries (power of two)
TAG_W, 4, tag width = log2(DEPTH); tag equals entry index

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; state frozen when low
ID_valid  in  1  allocate request
ID_reg_dest  in  5  destination register (0 = none)
ID_is_branch  in  1  entry is a branch/jump
ID_tag  out  TAG_W  tag granted to the current request (= tail)
ROB_full  out  1  no free entry; allocation refused
CDB_valid  in  1  completion broadcast
CDB_tag  in  TAG_W  completing entry
CDB_data  in  32  result value
CDB_mispredict  in  1  branch resolved opposite to prediction
CDB_target  in  32  correct PC for a mispredicted branch
QUERY1_tag  in  TAG_W  dispatch lookup 1
QUERY1_ready  out  1  entry 1 result available
QUERY1_data  out  32  entry 1 result
QUERY2_tag  in  TAG_W  dispatch lookup 2
QUERY2_ready  out  1  entry 2 result available
QUERY2_data  out  32  entry 2 result
ROB_data_valid  out  1  regfile commit strobe
ROB_reg_dest  out  5  committed destination
ROB_tag  out  TAG_W  committed tag
ROB_data  out  32  committed value
clear  out  1  flush pulse to all units, including the regfile
redirect_valid  out  1  PC redirect pulse
redirect_pc  out  32  redirect target

Behaviour:
- State:
  - Circular buffer with head (oldest), tail (next free) and count (0..DEPTH).
  - Per entry: busy, ready, dest, is_branch, mispredict, data, target.
- Reset (asynchronous):
  - head, tail and count are 0; all busy and ready bits are 0.
  - All outputs are 0, so ID_tag=0 and ROB_full=0.
- rdy low: all state holds; ROB_data_valid, clear and redirect_valid are 0 during that cycle.
- ROB_full is combinational: 1 when count==DEPTH.
  - No same-cycle bypass: allocation is refused at full even if a commit happens in the same cycle.
- Allocate: at the edge where ID_valid&&!ROB_full&&!clear:
  - entry[tail] loads busy=1, ready=0, dest, is_branch, mispredict=0.
  - tail increments mod DEPTH; tail wraps from DEPTH-1 to 0.
- Complete: at the edge where CDB_valid&&entry[CDB_tag].busy:
  - The entry sets ready=1 and latches data, mispredict and target.
  - A CDB hit on a non-busy entry is ignored.
- Commit: evaluated each cycle on registered state.
  - Condition: count>0 && entry[head].busy && entry[head].ready.
  - At the edge, the commit register loads ROB_data_valid=1, ROB_reg_dest=dest, ROB_tag=head and ROB_data=data.
  - Entry[head].busy clears, head increments mod DEPTH.
  - Otherwise ROB_data_valid is 0 next cycle.
  - Limited to one commit per cycle.
  - dest=0 entries still strobe with reg_dest=0; the regfile ignores them.
- Latency:
  - CDB at edge N sets ready.
  - Commit strobe is visible in the cycle after edge N+1 (2 edges minimum).
  - A completion to the head is never committed in the same edge.
- Count update: count = count + alloc − commit; simultaneous alloc+commit leaves count unchanged.
- Mispredict: when the committing head has is_branch&&mispredict:
  - Its register write is still issued (JAL/JALR link).
  - clear=1, redirect_valid=1 and redirect_pc=target are registered at the same edge and last one cycle.
  - At that edge head, tail and count become 0 and all busy bits clear.
  - Any allocation or CDB update in that edge is discarded.
- While clear is high: allocation is suppressed and CDB is ignored.
- Query (combinational, per port):
  - If CDB_valid&&CDB_tag==QUERYn_tag: ready=1, data=CDB_data.
  - Else: ready=entry.ready&&entry.busy, data=entry.data.
  - Data is don't-care (drive 0) when not ready.

Test Plan:
- Reset: assert rst mid-cycle with 3 entries allocated → outputs 0 immediately, before any clk edge; ROB_full=0, ID_tag=0.
- In-order retire:
  - Stimulus: allocate tags 0,1,2 (dest 5,6,7); CDB completes tag 2 then 1 then 0 with 0x22,0x11,0x0A.
  - Expected: commits appear in tag order 0,1,2 with data 0x0A,0x11,0x22; first strobe 2 edges after tag 0 completes.
- Full/wrap:
  - Stimulus: allocate 16 entries → ROB_full=1; a 17th request is refused and tail is unchanged.
  - Expected: after commits, allocation resumes at tag 0 once the entry frees (wrap).
- Simultaneous: at count=5, alloc and commit in the same edge → count stays 5, head+1, tail+1.
- Mispredict:
  - Stimulus: entries 0(branch, dest 1),1,2; tag 0 completes with mispredict=1, target=0x1000, data=0x44.
  - Expected: ROB_data_valid with reg 1=0x44, clear=1, redirect_pc=0x1000 in the same cycle; next cycle count=0 and ID_tag=0.
- Query bypass: QUERY1_tag=3 while CDB completes tag 3 with 0xBEEF → QUERY1_ready=1, data=0xBEEF in the same cycle; rdy=0 for 2 cycles freezes head and tail.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// In-order reorder buffer: allocates tags at dispatch, records CDB completions,
// retires the head into the regfile port one entry per cycle and flushes on a mispredicted branch.
module rob_commit_ctrl #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             ID_valid,
  input  logic [4:0]       ID_reg_dest,
  input  logic             ID_is_branch,
  output logic [TAG_W-1:0] ID_tag,
  output logic             ROB_full,
  input  logic             CDB_valid,
  input  logic [TAG_W-1:0] CDB_tag,
  input  logic [31:0]      CDB_data,
  input  logic             CDB_mispredict,
  input  logic [31:0]      CDB_target,
  input  logic [TAG_W-1:0] QUERY1_tag,
  output logic             QUERY1_ready,
  output logic [31:0]      QUERY1_data,
  input  logic [TAG_W-1:0] QUERY2_tag,
  output logic             QUERY2_ready,
  output logic [31:0]      QUERY2_data,
  output logic             ROB_data_valid,
  output logic [4:0]       ROB_reg_dest,
  output logic [TAG_W-1:0] ROB_tag,
  output logic [31:0]      ROB_data,
  output logic             clear,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic [DEPTH-1:0] busy_q, ready_q, br_q, mp_q;
  logic [4:0]       dest_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      tgt_q  [DEPTH];

  logic             cm_valid_q, cm_valid_d;
  logic [4:0]       cm_dest_q, cm_dest_d;
  logic [TAG_W-1:0] cm_tag_q, cm_tag_d;
  logic [31:0]      cm_data_q, cm_data_d;
  logic             clear_q, clear_d;
  logic [31:0]      redir_pc_q, redir_pc_d;

  logic full, commit_en, flush, alloc_en, cpl_en;

  // A flush discards any allocation or completion arriving at the same edge.
  always_comb begin
    full      = (count_q == (TAG_W+1)'(DEPTH));
    commit_en = rdy && (count_q != '0) && busy_q[head_q] && ready_q[head_q];
    flush     = commit_en && br_q[head_q] && mp_q[head_q];
    alloc_en  = rdy && ID_valid && !full && !clear_q && !flush;
    cpl_en    = rdy && CDB_valid && busy_q[CDB_tag] && !clear_q && !flush;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    cm_valid_d = cm_valid_q;
    cm_dest_d  = cm_dest_q;
    cm_tag_d   = cm_tag_q;
    cm_data_d  = cm_data_q;
    clear_d    = clear_q;
    redir_pc_d = redir_pc_q;
    if (rdy) begin
      cm_valid_d = commit_en;
      clear_d    = flush;
      if (commit_en) begin
        cm_dest_d = dest_q[head_q];
        cm_tag_d  = head_q;
        cm_data_d = data_q[head_q];
      end
      if (flush) begin
        redir_pc_d = tgt_q[head_q];
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
      end else begin
        if (commit_en) head_d = head_q + 1'b1;
        if (alloc_en)  tail_d = tail_q + 1'b1;
        count_d = count_q + (TAG_W+1)'(alloc_en) - (TAG_W+1)'(commit_en);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cm_valid_q <= 1'b0;
      cm_dest_q  <= '0;
      cm_tag_q   <= '0;
      cm_data_q  <= '0;
      clear_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cm_valid_q <= cm_valid_d;
      cm_dest_q  <= cm_dest_d;
      cm_tag_q   <= cm_tag_d;
      cm_data_q  <= cm_data_d;
      clear_q    <= clear_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else if (flush) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else begin
      if (cpl_en)    ready_q[CDB_tag] <= 1'b1;
      if (commit_en) busy_q[head_q]   <= 1'b0;
      if (alloc_en) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
      end
    end
  end

  // Payload is only meaningful while the matching busy bit is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      dest_q[tail_q] <= ID_reg_dest;
      br_q[tail_q]   <= ID_is_branch;
      mp_q[tail_q]   <= 1'b0;
    end
    if (cpl_en) begin
      data_q[CDB_tag] <= CDB_data;
      mp_q[CDB_tag]   <= CDB_mispredict;
      tgt_q[CDB_tag]  <= CDB_target;
    end
  end

  always_comb begin
    QUERY1_ready = 1'b0;
    QUERY1_data  = '0;
    QUERY2_ready = 1'b0;
    QUERY2_data  = '0;
    if (CDB_valid && CDB_tag == QUERY1_tag) begin
      QUERY1_ready = 1'b1;
      QUERY1_data  = CDB_data;
    end else if (busy_q[QUERY1_tag] && ready_q[QUERY1_tag]) begin
      QUERY1_ready = 1'b1;
      QUERY1_data  = data_q[QUERY1_tag];
    end
    if (CDB_valid && CDB_tag == QUERY2_tag) begin
      QUERY2_ready = 1'b1;
      QUERY2_data  = CDB_data;
    end else if (busy_q[QUERY2_tag] && ready_q[QUERY2_tag]) begin
      QUERY2_ready = 1'b1;
      QUERY2_data  = data_q[QUERY2_tag];
    end
  end

  // Pulses are held while rdy is low so a pending commit is not lost, but only shown when enabled.
  assign ID_tag         = tail_q;
  assign ROB_full       = full;
  assign ROB_data_valid = cm_valid_q && rdy;
  assign ROB_reg_dest   = cm_dest_q;
  assign ROB_tag        = cm_tag_q;
  assign ROB_data       = cm_data_q;
  assign clear          = clear_q && rdy;
  assign redirect_valid = clear_q && rdy;
  assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: a queue-of-instructions model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ID_valid, ID_is_branch;
  logic [4:0]  ID_reg_dest;
  logic [3:0]  ID_tag;
  logic        ROB_full;
  logic        CDB_valid, CDB_mispredict;
  logic [3:0]  CDB_tag;
  logic [31:0] CDB_data, CDB_target;
  logic [3:0]  QUERY1_tag, QUERY2_tag;
  logic        QUERY1_ready, QUERY2_ready;
  logic [31:0] QUERY1_data, QUERY2_data;
  logic        ROB_data_valid;
  logic [4:0]  ROB_reg_dest;
  logic [3:0]  ROB_tag;
  logic [31:0] ROB_data;
  logic        clear, redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  rob_commit_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ID_valid(ID_valid), .ID_reg_dest(ID_reg_dest), .ID_is_branch(ID_is_branch),
    .ID_tag(ID_tag), .ROB_full(ROB_full),
    .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
    .CDB_mispredict(CDB_mispredict), .CDB_target(CDB_target),
    .QUERY1_tag(QUERY1_tag), .QUERY1_ready(QUERY1_ready), .QUERY1_data(QUERY1_data),
    .QUERY2_tag(QUERY2_tag), .QUERY2_ready(QUERY2_ready), .QUERY2_data(QUERY2_data),
    .ROB_data_valid(ROB_data_valid), .ROB_reg_dest(ROB_reg_dest), .ROB_tag(ROB_tag),
    .ROB_data(ROB_data), .clear(clear), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: in-flight instructions in age order ----------------
  typedef struct packed {
    logic [3:0]  tag;
    logic [4:0]  dest;
    logic        br;
    logic        rd;
    logic        mp;
    logic [31:0] data;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m_q[$];
  int          m_tail;
  logic        p_valid, p_clear;
  logic [4:0]  p_dest;
  logic [3:0]  p_tag;
  logic [31:0] p_data, p_pc;
  ent_t        m_h, m_n;
  bit          m_commit, m_flush, m_alloc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_tail = 0;
      p_valid = 0; p_clear = 0; p_dest = 0; p_tag = 0; p_data = 0; p_pc = 0;
    end else if (rdy) begin
      m_commit = (m_q.size() > 0) && m_q[0].rd;
      m_flush  = m_commit && m_q[0].br && m_q[0].mp;
      m_alloc  = ID_valid && (m_q.size() < 16) && !p_clear && !m_flush;
      if (m_commit) m_h = m_q[0];
      if (CDB_valid && !p_clear && !m_flush)
        foreach (m_q[i])
          if (m_q[i].tag == CDB_tag) begin
            m_q[i].rd   = 1'b1;
            m_q[i].data = CDB_data;
            m_q[i].mp   = CDB_mispredict;
            m_q[i].tgt  = CDB_target;
          end
      p_valid = m_commit;
      p_clear = m_flush;
      if (m_commit) begin
        void'(m_q.pop_front());
        p_dest = m_h.dest;
        p_tag  = m_h.tag;
        p_data = m_h.data;
      end
      if (m_flush) begin
        p_pc = m_h.tgt;
        m_q.delete();
        m_tail = 0;
      end
      if (m_alloc) begin
        m_n.tag  = 4'(m_tail);
        m_n.dest = ID_reg_dest;
        m_n.br   = ID_is_branch;
        m_n.rd   = 1'b0;
        m_n.mp   = 1'b0;
        m_n.data = '0;
        m_n.tgt  = '0;
        m_q.push_back(m_n);
        m_tail = (m_tail + 1) % 16;
      end
    end
  end

  function automatic void q_model(input logic [3:0] t, output logic r, output logic [31:0] d);
    r = 1'b0;
    d = '0;
    if (CDB_valid && CDB_tag == t) begin
      r = 1'b1;
      d = CDB_data;
    end else begin
      foreach (m_q[i])
        if (m_q[i].tag == t && m_q[i].rd) begin
          r = 1'b1;
          d = m_q[i].data;
        end
    end
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  logic        c_r;
  logic [31:0] c_d;

  always @(negedge clk) begin
    chk("ID_tag", 32'(ID_tag), 32'(m_tail));
    chk("ROB_full", 32'(ROB_full), 32'(m_q.size() == 16));
    chk("ROB_data_valid", 32'(ROB_data_valid), 32'(p_valid && rdy));
    if (p_valid && rdy) begin
      chk("ROB_reg_dest", 32'(ROB_reg_dest), 32'(p_dest));
      chk("ROB_tag", 32'(ROB_tag), 32'(p_tag));
      chk("ROB_data", ROB_data, p_data);
    end
    chk("clear", 32'(clear), 32'(p_clear && rdy));
    chk("redirect_valid", 32'(redirect_valid), 32'(p_clear && rdy));
    if (p_clear && rdy) chk("redirect_pc", redirect_pc, p_pc);
    q_model(QUERY1_tag, c_r, c_d);
    chk("QUERY1_ready", 32'(QUERY1_ready), 32'(c_r));
    chk("QUERY1_data", QUERY1_data, c_d);
    q_model(QUERY2_tag, c_r, c_d);
    chk("QUERY2_ready", 32'(QUERY2_ready), 32'(c_r));
    chk("QUERY2_data", QUERY2_data, c_d);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_alloc(input logic [4:0] d, input logic br);
    ID_valid = 1'b1;
    ID_reg_dest = d;
    ID_is_branch = br;
    cyc();
    ID_valid = 1'b0;
    ID_is_branch = 1'b0;
  endtask

  task automatic do_cdb(input logic [3:0] t, input logic [31:0] d, input logic mp, input logic [31:0] tgt);
    CDB_valid = 1'b1;
    CDB_tag = t;
    CDB_data = d;
    CDB_mispredict = mp;
    CDB_target = tgt;
    cyc();
    CDB_valid = 1'b0;
    CDB_mispredict = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; rdy = 1'b1;
    ID_valid = 0; ID_reg_dest = 0; ID_is_branch = 0;
    CDB_valid = 0; CDB_tag = 0; CDB_data = 0; CDB_mispredict = 0; CDB_target = 0;
    QUERY1_tag = 0; QUERY2_tag = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("lit_reset_tag", 32'(ID_tag), 32'd0);
    chk("lit_reset_full", 32'(ROB_full), 32'd0);
    chk("lit_reset_valid", 32'(ROB_data_valid), 32'd0);

    // in-order retire with out-of-order completion
    do_alloc(5'd5, 1'b0);
    do_alloc(5'd6, 1'b0);
    do_alloc(5'd7, 1'b0);
    chk("lit_tail_after3", 32'(ID_tag), 32'd3);
    do_cdb(4'd2, 32'h22, 1'b0, 32'h0);
    do_cdb(4'd1, 32'h11, 1'b0, 32'h0);
    do_cdb(4'd0, 32'h0A, 1'b0, 32'h0);
    chk("lit_no_same_edge_commit", 32'(ROB_data_valid), 32'd0);
    cyc();
    chk("lit_c0_valid", 32'(ROB_data_valid), 32'd1);
    chk("lit_c0_tag", 32'(ROB_tag), 32'd0);
    chk("lit_c0_dest", 32'(ROB_reg_dest), 32'd5);
    chk("lit_c0_data", ROB_data, 32'h0A);
    cyc();
    chk("lit_c1_tag", 32'(ROB_tag), 32'd1);
    chk("lit_c1_data", ROB_data, 32'h11);
    cyc();
    chk("lit_c2_dest", 32'(ROB_reg_dest), 32'd7);
    chk("lit_c2_data", ROB_data, 32'h22);
    cyc();
    chk("lit_c_idle", 32'(ROB_data_valid), 32'd0);

    // asynchronous reset mid-cycle with entries allocated
    do_alloc(5'd1, 1'b0);
    do_alloc(5'd2, 1'b0);
    do_alloc(5'd3, 1'b0);
    chk("lit_pre_rst_tag", 32'(ID_tag), 32'd6);
    #1 rst = 1'b1;
    #1;
    chk("lit_async_rst_tag", 32'(ID_tag), 32'd0);
    chk("lit_async_rst_full", 32'(ROB_full), 32'd0);
    cyc();
    rst = 1'b0;

    // fill, refuse, wrap
    for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 1'b0);
    chk("lit_full", 32'(ROB_full), 32'd1);
    chk("lit_full_tag", 32'(ID_tag), 32'd0);
    ID_valid = 1'b1; ID_reg_dest = 5'd31;
    cyc();
    chk("lit_refused_tag", 32'(ID_tag), 32'd0);
    do_cdb(4'd0, 32'h100, 1'b0, 32'h0);
    cyc();
    chk("lit_full_commit_valid", 32'(ROB_data_valid), 32'd1);
    chk("lit_no_bypass_tag", 32'(ID_tag), 32'd0);
    chk("lit_freed_full", 32'(ROB_full), 32'd0);
    cyc();
    chk("lit_wrap_tag", 32'(ID_tag), 32'd1);
    chk("lit_wrap_full", 32'(ROB_full), 32'd1);
    ID_valid = 1'b0;

    // drain to five entries, then simultaneous alloc + commit
    for (int t = 1; t <= 11; t++) do_cdb(4'(t), 32'h1000 + 32'(t), 1'b0, 32'h0);
    cyc();
    cyc();
    chk("lit_five_tag", 32'(ID_tag), 32'd1);
    do_cdb(4'd12, 32'hC0C0, 1'b0, 32'h0);
    ID_valid = 1'b1; ID_reg_dest = 5'd9;
    cyc();
    ID_valid = 1'b0;
    chk("lit_sim_commit_tag", 32'(ROB_tag), 32'd12);
    chk("lit_sim_tail", 32'(ID_tag), 32'd2);
    for (int i = 0; i < 10; i++) do_alloc(5'd10, 1'b0);
    chk("lit_count_stayed_not_full", 32'(ROB_full), 32'd0);
    do_alloc(5'd10, 1'b0);
    chk("lit_count_stayed_full", 32'(ROB_full), 32'd1);
    chk("lit_count_stayed_tag", 32'(ID_tag), 32'd13);

    // mispredicted branch at commit
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    do_alloc(5'd1, 1'b1);
    do_alloc(5'd2, 1'b0);
    do_alloc(5'd3, 1'b0);
    do_cdb(4'd0, 32'h44, 1'b1, 32'h1000);
    ID_valid = 1'b1; ID_reg_dest = 5'd4;
    CDB_valid = 1'b1; CDB_tag = 4'd1; CDB_data = 32'h55;
    cyc();
    chk("lit_mp_valid", 32'(ROB_data_valid), 32'd1);
    chk("lit_mp_dest", 32'(ROB_reg_dest), 32'd1);
    chk("lit_mp_data", ROB_data, 32'h44);
    chk("lit_mp_clear", 32'(clear), 32'd1);
    chk("lit_mp_redirect", 32'(redirect_valid), 32'd1);
    chk("lit_mp_pc", redirect_pc, 32'h1000);
    chk("lit_mp_tag", 32'(ID_tag), 32'd0);
    cyc();
    chk("lit_clear_suppress_tag", 32'(ID_tag), 32'd0);
    chk("lit_clear_pulse", 32'(clear), 32'd0);
    CDB_valid = 1'b0;
    cyc();
    chk("lit_after_clear_alloc", 32'(ID_tag), 32'd1);
    ID_valid = 1'b0;

    // query bypass and rdy freeze
    do_alloc(5'd11, 1'b0);
    do_alloc(5'd12, 1'b0);
    do_alloc(5'd13, 1'b0);
    QUERY1_tag = 4'd3; QUERY2_tag = 4'd2;
    #1;
    chk("lit_q1_not_ready", 32'(QUERY1_ready), 32'd0);
    CDB_valid = 1'b1; CDB_tag = 4'd3; CDB_data = 32'hBEEF;
    #1;
    chk("lit_q1_bypass_ready", 32'(QUERY1_ready), 32'd1);
    chk("lit_q1_bypass_data", QUERY1_data, 32'hBEEF);
    chk("lit_q2_not_ready", 32'(QUERY2_ready), 32'd0);
    cyc();
    CDB_valid = 1'b0;
    #1;
    chk("lit_q1_stored_data", QUERY1_data, 32'hBEEF);
    rdy = 1'b0;
    ID_valid = 1'b1; ID_reg_dest = 5'd8;
    CDB_valid = 1'b1; CDB_tag = 4'd0; CDB_data = 32'h77;
    cyc();
    cyc();
    chk("lit_freeze_tag", 32'(ID_tag), 32'd4);
    rdy = 1'b1;
    ID_valid = 1'b0;
    cyc();
    CDB_valid = 1'b0;
    cyc();
    chk("lit_thaw_commit_data", ROB_data, 32'h77);
    chk("lit_thaw_commit_dest", 32'(ROB_reg_dest), 32'd4);
    do_cdb(4'd1, 32'h81, 1'b0, 32'h0);
    do_cdb(4'd2, 32'h82, 1'b0, 32'h0);
    repeat (4) cyc();
    chk("lit_final_full", 32'(ROB_full), 32'd0);
    chk("lit_final_tag", 32'(ID_tag), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
